toggle_debounce: RTL and testbench

- Upstream conditioning stage for the toggle flip-flop.
- Takes a raw, asynchronous, bouncing push-button or strobe input and synchronizes it to clk.
- Debounces it with a cycle counter and FSM, then emits a clean single-cycle toggle pulse, with optional auto-repeat while held.
- t_pulse connects directly to the flip-flop's t input; both blocks share clk and reset.

---
 rtl/toggle_debounce_pkg.sv | 19 +
 rtl/sync_2ff.sv | 28 ++
 rtl/toggle_debounce.sv | 146 ++++++++++++++
 tb/tb_toggle_debounce.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/toggle_debounce_pkg.sv
// Shared types for the push-button conditioning stage: FSM state
// encoding plus a small decode helper used by the top level.
package toggle_debounce_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  // True while a press or release is still being qualified.
  function automatic logic is_qualifying(input db_state_t s);
    return (s == PRESS_WAIT) || (s == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs. Both stages clear to 0
// on the synchronous active-low reset so a fresh run never sees stale data.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  // Metastability pipeline: first stage samples the raw input, second filters it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= {W{1'b0}};
      s2_q <= {W{1'b0}};
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/toggle_debounce.sv
// Debounces a raw push-button/strobe and turns each accepted press into a
// single-cycle toggle request, with optional auto-repeat while held. The
// same counter width serves the debounce and repeat counters.
module toggle_debounce
  import toggle_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 0,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic enable,
  output logic t_pulse,
  output logic btn_level,
  output logic busy
);

  // A zero debounce length would accept a press on its very first sample.
  generate
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2**CNT_W) - 1) begin : g_bad_debounce
      $error("toggle_debounce: DEBOUNCE_CYCLES out of range 1..2**CNT_W-1");
    end
    if (REPEAT_CYCLES < 0 || REPEAT_CYCLES > (2**CNT_W) - 1) begin : g_bad_repeat
      $error("toggle_debounce: REPEAT_CYCLES out of range 0..2**CNT_W-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DB_LIMIT  = CNT_W'(DEBOUNCE_CYCLES);
  // Only meaningful when auto-repeat is enabled.
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic             REPEAT_EN = (REPEAT_CYCLES > 0) ? 1'b1 : 1'b0;

  logic             sync_s;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rpt_q, rpt_d;
  logic             t_pulse_q, t_pulse_d;
  logic             level_q, level_d;
  logic             busy_q, busy_d;

  sync_2ff #(.W(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (btn_in),
    .q_o   (sync_s)
  );

  // Next-state, counter and output decode for the debounce FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rpt_d     = rpt_q;
    t_pulse_d = 1'b0;
    level_d   = level_q;

    case (state_q)
      IDLE: begin
        if (sync_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = IDLE;
        end
      end

      PRESS_WAIT: begin
        if (!sync_s) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LIMIT) begin
          state_d   = PRESSED;
          rpt_d     = CNT_ZERO;
          t_pulse_d = enable;
          level_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      PRESSED: begin
        if (!sync_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else if (REPEAT_EN) begin
          if (rpt_q == RPT_LAST) begin
            t_pulse_d = enable;
            rpt_d     = CNT_ZERO;
          end else begin
            rpt_d = rpt_q + CNT_ONE;
          end
        end else begin
          rpt_d = rpt_q;
        end
      end

      RELEASE_WAIT: begin
        // A return to high here is release bounce, not a new press.
        if (sync_s) begin
          state_d = PRESSED;
          rpt_d   = CNT_ZERO;
        end else if (cnt_q == DB_LIMIT) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
        rpt_d   = CNT_ZERO;
        level_d = 1'b0;
      end
    endcase

    busy_d = is_qualifying(state_d);
  end

  // State and registered-output update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      rpt_q     <= CNT_ZERO;
      t_pulse_q <= 1'b0;
      level_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rpt_q     <= rpt_d;
      t_pulse_q <= t_pulse_d;
      level_q   <= level_d;
      busy_q    <= busy_d;
    end
  end

  assign t_pulse   = t_pulse_q;
  assign btn_level = level_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_toggle_debounce.sv
// Bench for toggle_debounce: three configurations share one stimulus
// stream; a run-length reference model predicts every output each cycle.
module tb_toggle_debounce;

  localparam int NI = 3;
  localparam int DPAR [NI] = '{4, 4, 1};
  localparam int RPAR [NI] = '{0, 8, 1};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_in = 1'b0;
  logic       enable = 1'b1;
  logic [NI-1:0] tp, lv, bz;

  always #5 clk = ~clk;

  toggle_debounce #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .btn_in(btn_in), .enable(enable),
    .t_pulse(tp[0]), .btn_level(lv[0]), .busy(bz[0]));
  toggle_debounce #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .btn_in(btn_in), .enable(enable),
    .t_pulse(tp[1]), .btn_level(lv[1]), .busy(bz[1]));
  toggle_debounce #(.DEBOUNCE_CYCLES(1), .REPEAT_CYCLES(1), .CNT_W(4)) u2 (
    .clk(clk), .reset(reset), .btn_in(btn_in), .enable(enable),
    .t_pulse(tp[2]), .btn_level(lv[2]), .busy(bz[2]));

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Reference model: btn_in reaches the decision logic two edges later;
  // a level flips after DEBOUNCE+1 consecutive opposing samples.
  logic hist [$];
  logic m_lvl  [NI];
  logic m_pul  [NI];
  int   m_run  [NI];
  int   m_held [NI];

  // Observation helpers for the directed phases.
  int   pcnt [NI];
  int   first_p0;
  logic tff_q;

  task automatic check_bit(input string tag, input int idx, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d] cyc %0d observed %b expected %b", tag, idx, cyc, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc %0d observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic s;
    if (!reset) begin
      hist = {1'b0, 1'b0};
      for (int i = 0; i < NI; i++) begin
        m_lvl[i] = 1'b0; m_pul[i] = 1'b0; m_run[i] = 0; m_held[i] = 0;
      end
    end else begin
      s = hist.pop_front();
      hist.push_back(btn_in);
      for (int i = 0; i < NI; i++) begin
        m_pul[i] = 1'b0;
        if (s != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DPAR[i] + 1) begin
            m_lvl[i] = s;
            m_run[i] = 0;
            if (s) begin
              m_pul[i]  = enable;
              m_held[i] = 0;
            end
          end
        end else begin
          if (m_lvl[i] && m_run[i] > 0) begin
            m_held[i] = 0;
          end else if (m_lvl[i] && RPAR[i] > 0) begin
            m_held[i]++;
            if (m_held[i] == RPAR[i]) begin
              m_pul[i]  = enable;
              m_held[i] = 0;
            end
          end
          m_run[i] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check_bit("t_pulse",   i, tp[i], m_pul[i]);
      check_bit("btn_level", i, lv[i], m_lvl[i]);
      check_bit("busy",      i, bz[i], (m_run[i] > 0) ? 1'b1 : 1'b0);
      if (tp[i] === 1'b1) pcnt[i]++;
    end
    if (tp[0] === 1'b1) begin
      tff_q = ~tff_q;
      if (first_p0 < 0) first_p0 = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int c0;
    int p0, p1;
    hist = {1'b0, 1'b0};
    for (int i = 0; i < NI; i++) begin
      m_lvl[i] = 1'b0; m_pul[i] = 1'b0; m_run[i] = 0; m_held[i] = 0; pcnt[i] = 0;
    end
    first_p0 = -1;
    tff_q    = 1'b0;

    // Reset state
    reset = 1'b0; btn_in = 1'b0; enable = 1'b1;
    run(3);
    reset = 1'b1;
    run(5);

    // Clean press held 40 cycles: one pulse (u0), repeat every 8 (u1)
    p0 = pcnt[0]; p1 = pcnt[1]; first_p0 = -1; c0 = cyc;
    btn_in = 1'b1;
    run(40);
    btn_in = 1'b0;
    run(12);
    check_int("clean_pulse_count",  pcnt[0] - p0, 1);
    check_int("clean_pulse_time",   first_p0, c0 + 7);
    check_int("repeat_pulse_count", pcnt[1] - p1, 5);
    check_int("tff_after_press",    int'(tff_q), 1);

    // Glitch shorter than the debounce window
    p0 = pcnt[0];
    btn_in = 1'b1;
    run(3);
    btn_in = 1'b0;
    run(10);
    check_int("glitch_no_pulse", pcnt[0] - p0, 0);

    // Accepted press followed by bouncy release
    p0 = pcnt[0];
    btn_in = 1'b1; run(12);
    btn_in = 1'b0; run(2);
    btn_in = 1'b1; run(2);
    btn_in = 1'b0; run(2);
    btn_in = 1'b1; run(2);
    btn_in = 1'b0; run(12);
    check_int("bounce_single_pulse", pcnt[0] - p0, 1);

    // Enable low across the qualifying edge drops the pulse
    p0 = pcnt[0];
    enable = 1'b0; btn_in = 1'b1; run(10);
    check_bit("gated_level", 0, lv[0], 1'b1);
    enable = 1'b1; run(3);
    btn_in = 1'b0; run(12);
    check_int("gated_no_pulse", pcnt[0] - p0, 0);
    btn_in = 1'b1; run(10);
    btn_in = 1'b0; run(12);
    check_int("enabled_one_pulse", pcnt[0] - p0, 1);

    // Reset while in PRESS_WAIT, button still held
    p0 = pcnt[0];
    btn_in = 1'b1; run(4);
    reset = 1'b0; run(1);
    c0 = cyc; first_p0 = -1;
    reset = 1'b1; run(12);
    check_int("post_reset_pulse_time", first_p0, c0 + 7);
    check_int("post_reset_pulse_count", pcnt[0] - p0, 1);
    btn_in = 1'b0; run(12);

    // Randomized bursts with random enable and occasional reset
    for (int b = 0; b < 300; b++) begin
      int len;
      btn_in = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        enable = ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0;
        reset  = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
        tick();
      end
    end
    reset = 1'b1;
    btn_in = 1'b0;
    run(12);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
